// File: rtl/disp_fetchctrl_if.sv
// AXI read-address and read-data handshake signals between the frame fetcher and the interconnect.
// The fetcher is the AXI master; the slave modport is for the interconnect or a bench model.
interface disp_fetchctrl_if;
    logic [31:0] ARADDR;
    logic [7:0]  ARLEN;
    logic        ARVALID;
    logic        ARREADY;
    logic        RVALID;
    logic        RLAST;
    logic        RREADY;

    modport master (
        output ARADDR, ARLEN, ARVALID, RREADY,
        input  ARREADY, RVALID, RLAST
    );

    modport slave (
        input  ARADDR, ARLEN, ARVALID, RREADY,
        output ARREADY, RVALID, RLAST
    );
endinterface

// File: rtl/disp_fetchctrl.sv
// Frame-fetch sequencer: on each VSYNC fall, latches the frame base and issues AXI read bursts
// for one frame. A burst is admitted only when the pixel FIFO is guaranteed to have room for it.
module disp_fetchctrl #(
    parameter int unsigned H_PIXELS   = 640,
    parameter int unsigned V_LINES    = 480,
    parameter int unsigned BURST_LEN  = 16,
    parameter int unsigned FIFO_DEPTH = 512,
    parameter int unsigned MAX_OUTST  = 4,
    parameter int unsigned LEVEL_W    = 10
) (
    input  logic               ACLK,
    input  logic               ARSTN,
    input  logic               DSP_VSYNC_X,
    input  logic               DISPON,
    input  logic [28:0]        DISPADDR,
    input  logic [LEVEL_W-1:0] BUF_LEVEL,
    disp_fetchctrl_if.master   axi,
    output logic               FETCH_BUSY,
    output logic               FRAME_DONE,
    output logic               FRAME_ERR
);

    localparam int unsigned NBURST     = H_PIXELS * V_LINES / BURST_LEN;
    localparam int unsigned IdxW       = $clog2(NBURST + 1);
    localparam int unsigned OutW       = $clog2(MAX_OUTST + 1);
    localparam int unsigned SumW       = LEVEL_W + 4;
    localparam int unsigned BurstBytes = BURST_LEN * 4;

    typedef enum logic [1:0] {StIdle, StIssue, StDrain, StAbort} state_e;

    state_e            state_q;
    logic [2:0]        sync_q;
    logic [28:0]       base_q;
    logic [IdxW-1:0]   idx_q;
    logic [OutW-1:0]   outst_q;
    logic              arvalid_q;
    logic [31:0]       araddr_q;
    logic              rready_q;
    logic              busy_q;
    logic              done_q;
    logic              err_q;

    logic              vs;
    logic              ar_hs;
    logic              r_last;
    logic [SumW-1:0]   space_need;
    logic              space_ok;
    logic              can_issue;
    logic              last_idx;
    logic [28:0]       burst_addr;

    // sync_q[0] is the first flop; a frame start is a 1->0 transition seen between flops 2 and 1.
    assign vs     = !sync_q[1] && sync_q[2];
    assign ar_hs  = arvalid_q && axi.ARREADY;
    assign r_last = axi.RVALID && rready_q && axi.RLAST;

    // Room must exist for every outstanding burst plus the candidate, on top of the current fill.
    assign space_need = SumW'(BUF_LEVEL) + SumW'((32'(outst_q) + 32'd1) * BURST_LEN);
    assign space_ok   = space_need <= SumW'(FIFO_DEPTH);
    assign can_issue  = !arvalid_q && (32'(idx_q) < NBURST) && (32'(outst_q) < MAX_OUTST)
                        && space_ok;
    assign last_idx   = 32'(idx_q) == NBURST - 1;
    assign burst_addr = base_q + 29'(32'(idx_q) * BurstBytes);

    always_ff @(posedge ACLK or negedge ARSTN) begin
        if (!ARSTN) begin
            sync_q <= 3'b111;
        end else begin
            sync_q <= {sync_q[1:0], DSP_VSYNC_X};
        end
    end

    // Beats arriving with nothing outstanding (e.g. left over from before a reset) are ignored.
    always_ff @(posedge ACLK or negedge ARSTN) begin
        if (!ARSTN) begin
            outst_q <= '0;
        end else if (ar_hs && !r_last) begin
            outst_q <= outst_q + OutW'(1);
        end else if (!ar_hs && r_last && outst_q != '0) begin
            outst_q <= outst_q - OutW'(1);
        end
    end

    always_ff @(posedge ACLK or negedge ARSTN) begin
        if (!ARSTN) begin
            state_q   <= StIdle;
            base_q    <= '0;
            idx_q     <= '0;
            arvalid_q <= 1'b0;
            araddr_q  <= '0;
            rready_q  <= 1'b0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
            err_q     <= 1'b0;
        end else begin
            rready_q <= 1'b1;
            done_q   <= 1'b0;
            err_q    <= 1'b0;
            // A pending request always completes, whatever the state does this cycle.
            if (ar_hs) begin
                arvalid_q <= 1'b0;
                idx_q     <= idx_q + IdxW'(1);
            end
            unique case (state_q)
                StIdle: begin
                    if (vs && DISPON) begin
                        base_q  <= {DISPADDR[28:6], 6'b000000};
                        idx_q   <= '0;
                        state_q <= StIssue;
                        busy_q  <= 1'b1;
                    end
                end
                StIssue: begin
                    if (vs) begin
                        err_q   <= 1'b1;
                        state_q <= StAbort;
                    end else if (!DISPON) begin
                        state_q <= StAbort;
                    end else if (ar_hs && last_idx) begin
                        state_q <= StDrain;
                    end else if (can_issue) begin
                        arvalid_q <= 1'b1;
                        araddr_q  <= {3'b000, burst_addr};
                    end
                end
                StDrain: begin
                    if (vs) begin
                        err_q   <= 1'b1;
                        state_q <= StAbort;
                    end else if (outst_q == '0) begin
                        done_q  <= 1'b1;
                        state_q <= StIdle;
                        busy_q  <= 1'b0;
                    end
                end
                StAbort: begin
                    if (!arvalid_q && outst_q == '0) begin
                        state_q <= StIdle;
                        busy_q  <= 1'b0;
                    end
                end
                default: state_q <= StIdle;
            endcase
        end
    end

    assign axi.ARADDR  = araddr_q;
    assign axi.ARLEN   = 8'(BURST_LEN - 1);
    assign axi.ARVALID = arvalid_q;
    assign axi.RREADY  = rready_q;
    assign FETCH_BUSY  = busy_q;
    assign FRAME_DONE  = done_q;
    assign FRAME_ERR   = err_q;

endmodule

// File: tb/tb_disp_fetchctrl.sv
// Bench for disp_fetchctrl: directed frame scenarios plus randomized frames checked against
// a transaction-level model of burst addresses, FIFO admission and outstanding-burst accounting.
module tb_disp_fetchctrl;
    localparam int unsigned BL    = 16;
    localparam int unsigned DEPTH = 512;
    localparam int unsigned MAXO  = 2;
    localparam int unsigned NB    = 4;

    logic        ACLK     = 1'b0;
    logic        ARSTN    = 1'b1;
    logic        vsync_x  = 1'b1;
    logic        dispon   = 1'b0;
    logic [28:0] dispaddr = '0;
    logic [9:0]  buf_level = '0;
    logic        fetch_busy;
    logic        frame_done;
    logic        frame_err;

    disp_fetchctrl_if axi ();

    disp_fetchctrl #(
        .H_PIXELS  (16),
        .V_LINES   (4),
        .BURST_LEN (BL),
        .FIFO_DEPTH(DEPTH),
        .MAX_OUTST (MAXO),
        .LEVEL_W   (10)
    ) dut (
        .ACLK       (ACLK),
        .ARSTN      (ARSTN),
        .DSP_VSYNC_X(vsync_x),
        .DISPON     (dispon),
        .DISPADDR   (dispaddr),
        .BUF_LEVEL  (buf_level),
        .axi        (axi),
        .FETCH_BUSY (fetch_busy),
        .FRAME_DONE (frame_done),
        .FRAME_ERR  (frame_err)
    );

    always #5 ACLK = ~ACLK;

    int          n_total = 0;
    int          n_pass  = 0;
    int          m_outst = 0;
    int          cyc = 0;
    int          done_cnt = 0;
    int          err_cnt = 0;
    int          long_pulse = 0;
    int          last_rl_cyc = 0;
    int          done_cyc = 0;
    bit          prev_done = 0;
    bit          prev_err = 0;
    bit          auto_r = 0;
    bit          ar_rand = 0;
    logic        ar_fixed = 1'b1;
    int          r_dmin = 2;
    int          r_dmax = 4;
    logic [31:0] ar_log[$];
    int          rq[$];

    // One clock: account handshakes/beats seen at this edge, then drive the slave side.
    task automatic step();
        logic        hs;
        logic        rl;
        logic [31:0] a;
        hs = axi.ARVALID && axi.ARREADY;
        rl = axi.RVALID && axi.RLAST && axi.RREADY;
        a  = axi.ARADDR;
        @(posedge ACLK);
        #1;
        cyc++;
        if (hs === 1'b1) begin
            ar_log.push_back(a);
            m_outst++;
            if (auto_r) rq.push_back($urandom_range(r_dmax, r_dmin));
        end
        if (rl === 1'b1 && m_outst > 0) begin
            m_outst--;
            last_rl_cyc = cyc;
        end
        if (frame_done === 1'b1) begin
            done_cnt++;
            done_cyc = cyc;
            if (prev_done) long_pulse++;
        end
        if (frame_err === 1'b1) begin
            err_cnt++;
            if (prev_err) long_pulse++;
        end
        prev_done = (frame_done === 1'b1);
        prev_err  = (frame_err === 1'b1);
        axi.ARREADY = ar_rand ? 1'($urandom_range(1, 0)) : ar_fixed;
        axi.RVALID  = 1'b0;
        axi.RLAST   = 1'b0;
        for (int i = 0; i < rq.size(); i++) rq[i] = rq[i] - 1;
        if (rq.size() > 0 && rq[0] <= 0) begin
            axi.RVALID = 1'b1;
            axi.RLAST  = 1'b1;
            void'(rq.pop_front());
        end
    endtask

    task automatic vs_pulse();
        vsync_x = 1'b0;
        repeat (3) step();
        vsync_x = 1'b1;
    endtask

    task automatic send_rlast();
        axi.RVALID = 1'b1;
        axi.RLAST  = 1'b1;
        step();
    endtask

    task automatic wait_idle(input int lim, output bit ok);
        int i;
        i = 0;
        while (fetch_busy && i < lim) begin
            step();
            i++;
        end
        ok = !fetch_busy;
    endtask

    task automatic test_reset();
        #2 ARSTN = 1'b0;
        #1;
        n_total++;
        if (axi.ARVALID !== 1'b0) $display("FAIL rst_arvalid got %b want 0", axi.ARVALID);
        else n_pass++;
        n_total++;
        if (axi.ARADDR !== 32'h0) $display("FAIL rst_araddr got %h want 0", axi.ARADDR);
        else n_pass++;
        n_total++;
        if (axi.ARLEN !== 8'd15) $display("FAIL rst_arlen got %0d want 15", axi.ARLEN);
        else n_pass++;
        n_total++;
        if (axi.RREADY !== 1'b0) $display("FAIL rst_rready got %b want 0", axi.RREADY);
        else n_pass++;
        n_total++;
        if (fetch_busy !== 1'b0) $display("FAIL rst_busy got %b want 0", fetch_busy);
        else n_pass++;
        n_total++;
        if (frame_done !== 1'b0) $display("FAIL rst_done got %b want 0", frame_done);
        else n_pass++;
        n_total++;
        if (frame_err !== 1'b0) $display("FAIL rst_err got %b want 0", frame_err);
        else n_pass++;
        repeat (3) step();
        n_total++;
        if (axi.RREADY !== 1'b0) $display("FAIL rst_rready_hold got %b want 0", axi.RREADY);
        else n_pass++;
        ARSTN = 1'b1;
        step();
        n_total++;
        if (axi.RREADY !== 1'b1) $display("FAIL rready_after_rst got %b want 1", axi.RREADY);
        else n_pass++;
        dispon = 1'b1;
        repeat (6) step();
        n_total++;
        if (fetch_busy !== 1'b0) $display("FAIL no_spurious_vs busy got %b want 0", fetch_busy);
        else n_pass++;
    endtask

    task automatic test_frame_basic();
        int d0, e0;
        bit ok;
        ar_log.delete();
        dispaddr = 29'h0000_1040;
        buf_level = '0;
        ar_fixed = 1'b1;
        auto_r = 1;
        d0 = done_cnt;
        e0 = err_cnt;
        vs_pulse();
        wait_idle(300, ok);
        n_total++;
        if (!ok) $display("FAIL basic_timeout busy got 1 want 0"); else n_pass++;
        n_total++;
        if (ar_log.size() != NB) $display("FAIL basic_ar_count got %0d want %0d", ar_log.size(), NB);
        else n_pass++;
        for (int i = 0; i < ar_log.size() && i < NB; i++) begin
            n_total++;
            if (ar_log[i] !== 32'h1040 + 32'(i * 64))
                $display("FAIL basic_addr%0d got %h want %h", i, ar_log[i], 32'h1040 + 32'(i * 64));
            else n_pass++;
        end
        n_total++;
        if (done_cnt - d0 != 1) $display("FAIL basic_done got %0d want 1", done_cnt - d0);
        else n_pass++;
        n_total++;
        if (err_cnt != e0) $display("FAIL basic_err got %0d want 0", err_cnt - e0);
        else n_pass++;
        n_total++;
        if (done_cyc != last_rl_cyc + 1)
            $display("FAIL basic_done_timing got %0d want %0d", done_cyc, last_rl_cyc + 1);
        else n_pass++;
        n_total++;
        if (axi.ARLEN !== 8'd15) $display("FAIL basic_arlen got %0d want 15", axi.ARLEN);
        else n_pass++;
    endtask

    task automatic test_space_and_outstanding();
        int d0;
        ar_log.delete();
        auto_r = 0;
        ar_fixed = 1'b1;
        dispaddr = 29'h0000_2000;
        buf_level = 10'd500;
        d0 = done_cnt;
        vs_pulse();
        repeat (15) step();
        n_total++;
        if (ar_log.size() != 0) $display("FAIL space_500 got %0d ARs want 0", ar_log.size());
        else n_pass++;
        buf_level = 10'd496;
        repeat (8) step();
        n_total++;
        if (ar_log.size() != 1) $display("FAIL space_496 got %0d ARs want 1", ar_log.size());
        else n_pass++;
        buf_level = 10'd481;
        repeat (8) step();
        n_total++;
        if (ar_log.size() != 1) $display("FAIL space_481 got %0d ARs want 1", ar_log.size());
        else n_pass++;
        buf_level = 10'd480;
        repeat (8) step();
        n_total++;
        if (ar_log.size() != 2) $display("FAIL space_480 got %0d ARs want 2", ar_log.size());
        else n_pass++;
        buf_level = '0;
        repeat (10) step();
        n_total++;
        if (ar_log.size() != 2) $display("FAIL outst_limit got %0d ARs want 2", ar_log.size());
        else n_pass++;
        send_rlast();
        repeat (6) step();
        n_total++;
        if (ar_log.size() != 3) $display("FAIL outst_release got %0d ARs want 3", ar_log.size());
        else n_pass++;
        ar_fixed = 1'b0;
        send_rlast();
        for (int i = 0; i < 10 && axi.ARVALID !== 1'b1; i++) step();
        n_total++;
        if (axi.ARVALID !== 1'b1 || axi.ARADDR !== 32'h20C0)
            $display("FAIL outst_fourth got v=%b a=%h want v=1 a=000020c0", axi.ARVALID, axi.ARADDR);
        else n_pass++;
        // Accept the fourth AR in the same cycle as an RLAST: one burst stays outstanding.
        axi.ARREADY = 1'b1;
        axi.RVALID  = 1'b1;
        axi.RLAST   = 1'b1;
        ar_fixed = 1'b1;
        step();
        repeat (6) step();
        n_total++;
        if (done_cnt != d0 || fetch_busy !== 1'b1)
            $display("FAIL simul_hs got done=%0d busy=%b want done=0 busy=1", done_cnt - d0,
                     fetch_busy);
        else n_pass++;
        send_rlast();
        repeat (3) step();
        n_total++;
        if (done_cnt - d0 != 1 || fetch_busy !== 1'b0)
            $display("FAIL simul_finish got done=%0d busy=%b want done=1 busy=0", done_cnt - d0,
                     fetch_busy);
        else n_pass++;
        n_total++;
        if (ar_log.size() != NB) $display("FAIL space_total got %0d want %0d", ar_log.size(), NB);
        else n_pass++;
    endtask

    task automatic test_overrun();
        int d0, e0;
        bit ok;
        ar_log.delete();
        auto_r = 0;
        ar_fixed = 1'b1;
        buf_level = '0;
        dispaddr = 29'h0000_3000;
        d0 = done_cnt;
        e0 = err_cnt;
        vs_pulse();
        repeat (10) step();
        n_total++;
        if (ar_log.size() != 2) $display("FAIL ovr_pre got %0d ARs want 2", ar_log.size());
        else n_pass++;
        dispaddr = 29'h0000_5000;
        vs_pulse();
        n_total++;
        if (err_cnt - e0 != 1) $display("FAIL ovr_err got %0d want 1", err_cnt - e0);
        else n_pass++;
        repeat (10) step();
        n_total++;
        if (ar_log.size() != 2 || fetch_busy !== 1'b1)
            $display("FAIL ovr_noissue got ars=%0d busy=%b want ars=2 busy=1", ar_log.size(),
                     fetch_busy);
        else n_pass++;
        send_rlast();
        send_rlast();
        repeat (3) step();
        n_total++;
        if (fetch_busy !== 1'b0 || done_cnt != d0)
            $display("FAIL ovr_idle got busy=%b done=%0d want busy=0 done=0", fetch_busy,
                     done_cnt - d0);
        else n_pass++;
        ar_log.delete();
        auto_r = 1;
        vs_pulse();
        wait_idle(300, ok);
        n_total++;
        if (!ok || ar_log.size() != NB || ar_log[0] !== 32'h5000)
            $display("FAIL ovr_restart got ok=%b ars=%0d want ok=1 ars=%0d first=00005000", ok,
                     ar_log.size(), NB);
        else n_pass++;
        n_total++;
        if (done_cnt - d0 != 1) $display("FAIL ovr_restart_done got %0d want 1", done_cnt - d0);
        else n_pass++;
    endtask

    task automatic test_stall_dispon();
        int d0, e0;
        bit ok;
        logic [31:0] a0;
        ar_log.delete();
        auto_r = 1;
        ar_fixed = 1'b0;
        dispaddr = 29'h0000_6000;
        d0 = done_cnt;
        e0 = err_cnt;
        vs_pulse();
        for (int i = 0; i < 10 && axi.ARVALID !== 1'b1; i++) step();
        a0 = axi.ARADDR;
        n_total++;
        if (axi.ARVALID !== 1'b1 || a0 !== 32'h6000)
            $display("FAIL stall_start got v=%b a=%h want v=1 a=00006000", axi.ARVALID, a0);
        else n_pass++;
        for (int i = 0; i < 10; i++) begin
            if (i == 4) dispon = 1'b0;
            step();
            n_total++;
            if (axi.ARVALID !== 1'b1 || axi.ARADDR !== a0)
                $display("FAIL stall_hold%0d got v=%b a=%h want v=1 a=%h", i, axi.ARVALID,
                         axi.ARADDR, a0);
            else n_pass++;
        end
        ar_fixed = 1'b1;
        step();
        wait_idle(60, ok);
        n_total++;
        if (!ok || ar_log.size() != 1)
            $display("FAIL stall_abort got ok=%b ars=%0d want ok=1 ars=1", ok, ar_log.size());
        else n_pass++;
        n_total++;
        if (err_cnt != e0 || done_cnt != d0)
            $display("FAIL stall_pulses got err=%0d done=%0d want 0 0", err_cnt - e0,
                     done_cnt - d0);
        else n_pass++;
        dispon = 1'b1;
    endtask

    task automatic test_wrap_and_reset();
        int d0;
        bit ok;
        ar_log.delete();
        auto_r = 1;
        r_dmin = 8;
        r_dmax = 10;
        ar_fixed = 1'b1;
        dispaddr = 29'h1FFF_FFC0;
        vs_pulse();
        for (int i = 0; i < 20 && ar_log.size() < 2; i++) step();
        n_total++;
        if (ar_log.size() < 2 || ar_log[0] !== 32'h1FFF_FFC0 || ar_log[1] !== 32'h0)
            $display("FAIL wrap_addr got n=%0d want 1fffffc0 then 00000000", ar_log.size());
        else n_pass++;
        n_total++;
        if (fetch_busy !== 1'b1) $display("FAIL wrap_busy got %b want 1", fetch_busy);
        else n_pass++;
        #2 ARSTN = 1'b0;
        #1;
        n_total++;
        if (axi.ARVALID !== 1'b0 || axi.ARADDR !== 32'h0 || axi.RREADY !== 1'b0)
            $display("FAIL midrst_ar got v=%b a=%h r=%b want 0 0 0", axi.ARVALID, axi.ARADDR,
                     axi.RREADY);
        else n_pass++;
        n_total++;
        if (fetch_busy !== 1'b0 || frame_done !== 1'b0 || frame_err !== 1'b0)
            $display("FAIL midrst_status got b=%b d=%b e=%b want 0 0 0", fetch_busy, frame_done,
                     frame_err);
        else n_pass++;
        rq.delete();
        m_outst = 0;
        repeat (2) step();
        ARSTN = 1'b1;
        step();
        // A late beat from the aborted frame must not disturb the next one.
        send_rlast();
        r_dmin = 2;
        r_dmax = 4;
        ar_log.delete();
        dispaddr = 29'h0000_1040;
        d0 = done_cnt;
        vs_pulse();
        wait_idle(300, ok);
        n_total++;
        if (!ok || ar_log.size() != NB || done_cnt - d0 != 1)
            $display("FAIL post_rst_frame got ok=%b ars=%0d done=%0d want 1 %0d 1", ok,
                     ar_log.size(), NB, done_cnt - d0);
        else n_pass++;
    endtask

    task automatic test_random();
        logic [28:0] base;
        logic [31:0] pre_addr;
        logic        pre_av;
        logic        pre_rdy;
        int          pre_lvl;
        int          pre_o;
        int          d0, e0;
        bit          fit;
        ar_rand = 1;
        auto_r = 1;
        r_dmin = 1;
        r_dmax = 6;
        for (int f = 0; f < 5; f++) begin
            dispaddr = 29'($urandom);
            base = {dispaddr[28:6], 6'b000000};
            ar_log.delete();
            d0 = done_cnt;
            e0 = err_cnt;
            vs_pulse();
            for (int c = 0; c < 800 && fetch_busy; c++) begin
                buf_level = 10'($urandom_range(520, 0));
                pre_av = axi.ARVALID;
                pre_rdy = axi.ARREADY;
                pre_addr = axi.ARADDR;
                pre_lvl = int'(buf_level);
                pre_o = m_outst;
                step();
                if (!pre_av && axi.ARVALID) begin
                    fit = (pre_lvl + (pre_o + 1) * int'(BL) <= int'(DEPTH)) && (pre_o < int'(MAXO));
                    n_total++;
                    if (!fit)
                        $display("FAIL rnd_admit lvl=%0d outst=%0d got issue want none", pre_lvl,
                                 pre_o);
                    else n_pass++;
                end
                if (pre_av && !pre_rdy) begin
                    n_total++;
                    if (axi.ARVALID !== 1'b1 || axi.ARADDR !== pre_addr)
                        $display("FAIL rnd_hold got v=%b a=%h want v=1 a=%h", axi.ARVALID,
                                 axi.ARADDR, pre_addr);
                    else n_pass++;
                end
                if (pre_av && pre_rdy) begin
                    n_total++;
                    if (axi.ARVALID !== 1'b0)
                        $display("FAIL rnd_gap got v=%b want 0", axi.ARVALID);
                    else n_pass++;
                end
            end
            buf_level = '0;
            n_total++;
            if (fetch_busy !== 1'b0 || done_cnt - d0 != 1 || err_cnt != e0)
                $display("FAIL rnd_frame%0d got busy=%b done=%0d err=%0d want 0 1 0", f,
                         fetch_busy, done_cnt - d0, err_cnt - e0);
            else n_pass++;
            n_total++;
            if (ar_log.size() != NB)
                $display("FAIL rnd_count%0d got %0d want %0d", f, ar_log.size(), NB);
            else n_pass++;
            for (int i = 0; i < ar_log.size() && i < NB; i++) begin
                n_total++;
                if (ar_log[i] !== {3'b000, 29'(base + 29'(i * 64))})
                    $display("FAIL rnd_addr%0d_%0d got %h want %h", f, i, ar_log[i],
                             {3'b000, 29'(base + 29'(i * 64))});
                else n_pass++;
            end
            n_total++;
            if (axi.RREADY !== 1'b1) $display("FAIL rnd_rready got %b want 1", axi.RREADY);
            else n_pass++;
        end
        ar_rand = 0;
    endtask

    initial begin
        axi.ARREADY = 1'b0;
        axi.RVALID  = 1'b0;
        axi.RLAST   = 1'b0;
        test_reset();
        test_frame_basic();
        test_space_and_outstanding();
        test_overrun();
        test_stall_dispon();
        test_wrap_and_reset();
        test_random();
        n_total++;
        if (long_pulse != 0) $display("FAIL pulse_width got %0d long pulses want 0", long_pulse);
        else n_pass++;
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog got timeout want completion");
        $fatal(1, "watchdog");
    end

endmodule
